// File: rtl/floor_panel_pkg.sv
// Shared constants for the floor call panel: 7-segment glyphs (active low,
// {dp,g,f,e,d,c,b,a}) and the pbpulse field layout.
package floor_panel_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_U     = 8'hC1;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_N     = 8'hAB;

  // Index 0 is the rightmost element: glyphs for 0..F
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // pbpulse fields, in units of N_FLOORS bits: {dn, up}
  localparam int UP_LSB = 0;
  localparam int DN_LSB = 1;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    return HEX_GLYPH[v];
  endfunction

endpackage

// File: rtl/floor_call_panel_pb_debounce.sv
// One hall button: 2-flop sync, slowref-sampled debounce counter and a
// single-clock pulse on the rising edge of the clean level.
module pb_debounce #(
  parameter int DB_COUNT      = 4,
  parameter bit PB_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic resetb,
  input  logic slowref,
  input  logic i_raw,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_clean;
  logic       r_clean_d;
  logic       w_smp;

  assign w_smp = r_sync[1];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw ^ PB_ACTIVE_LOW};
      r_clean_d <= r_clean;
      if (slowref) begin
        if (w_smp == r_clean) begin
          r_cnt <= '0;
        end else if (r_cnt == 4'(DB_COUNT - 1)) begin
          // DB_COUNT consecutive differing samples: accept the new level
          r_clean <= ~r_clean;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  assign o_pulse = r_clean & ~r_clean_d;

endmodule

// File: rtl/floor_call_panel.sv
// Hall-button panel for N_FLOORS landings: debounced press pulses, latched
// up/down calls cleared by the car controller, and a 4-digit status display.
module floor_call_panel
  import floor_panel_pkg::*;
#(
  parameter  int N_FLOORS      = 4,
  parameter  int DB_COUNT      = 4,
  parameter  bit PB_ACTIVE_LOW = 1'b0,
  localparam int FLOOR_W       = $clog2(N_FLOORS)
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  slowref,
  input  logic [N_FLOORS-1:0]   pb_up,
  input  logic [N_FLOORS-1:0]   pb_dn,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic                  clrup,
  input  logic                  clrdn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  moving,
  input  logic                  upsig,
  input  logic                  dnsig,
  output logic [2*N_FLOORS-1:0] pbpulse,
  output logic [N_FLOORS-1:0]   call_up,
  output logic [N_FLOORS-1:0]   call_dn,
  output logic                  call_any,
  output logic [7:0]            seg3,
  output logic [7:0]            seg2,
  output logic [7:0]            seg1,
  output logic [7:0]            seg0
);

  logic [1:0][N_FLOORS-1:0] w_pulse;
  logic [N_FLOORS-1:0]      w_set_up, w_set_dn, w_clr_up, w_clr_dn;
  logic [N_FLOORS-1:0]      r_call_up, r_call_dn;
  logic                     r_call_any;
  logic [7:0]               r_seg3, r_seg2, r_seg1, r_seg0;

  for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
    localparam bit UP_KEEP = (f != N_FLOORS - 1);
    localparam bit DN_KEEP = (f != 0);
    logic w_up_raw, w_dn_raw, w_here;

    // Top-floor up and ground-floor down buttons are tied to their idle level
    assign w_up_raw = (pb_up[f] & UP_KEEP) | (PB_ACTIVE_LOW & ~UP_KEEP);
    assign w_dn_raw = (pb_dn[f] & DN_KEEP) | (PB_ACTIVE_LOW & ~DN_KEEP);

    pb_debounce #(.DB_COUNT(DB_COUNT), .PB_ACTIVE_LOW(PB_ACTIVE_LOW)) u_up (
      .clk(clk), .resetb(resetb), .slowref(slowref),
      .i_raw(w_up_raw), .o_pulse(w_pulse[UP_LSB][f])
    );
    pb_debounce #(.DB_COUNT(DB_COUNT), .PB_ACTIVE_LOW(PB_ACTIVE_LOW)) u_dn (
      .clk(clk), .resetb(resetb), .slowref(slowref),
      .i_raw(w_dn_raw), .o_pulse(w_pulse[DN_LSB][f])
    );

    // A press at the floor where the car stands idle is served immediately
    assign w_here      = (car_floor == FLOOR_W'(f)) && !moving;
    assign w_set_up[f] = w_pulse[UP_LSB][f] & ~w_here;
    assign w_set_dn[f] = w_pulse[DN_LSB][f] & ~w_here;
    assign w_clr_up[f] = clrup && (clr_floor == FLOOR_W'(f));
    assign w_clr_dn[f] = clrdn && (clr_floor == FLOOR_W'(f));
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_call_up  <= '0;
      r_call_dn  <= '0;
      r_call_any <= 1'b0;
    end else begin
      r_call_up  <= (r_call_up | w_set_up) & ~w_clr_up;
      r_call_dn  <= (r_call_dn | w_set_dn) & ~w_clr_dn;
      r_call_any <= |{r_call_up, r_call_dn};
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_seg3 <= SEG_BLANK;
      r_seg2 <= SEG_BLANK;
      r_seg1 <= SEG_BLANK;
      r_seg0 <= SEG_BLANK;
    end else begin
      r_seg1 <= SEG_BLANK;
      r_seg0 <= hex_glyph(4'(car_floor));
      if (moving && upsig && !dnsig) begin
        r_seg3 <= SEG_U;
        r_seg2 <= SEG_P;
      end else if (moving && dnsig && !upsig) begin
        r_seg3 <= SEG_D;
        r_seg2 <= SEG_N;
      end else begin
        r_seg3 <= SEG_BLANK;
        r_seg2 <= SEG_BLANK;
      end
    end
  end

  assign pbpulse  = w_pulse;
  assign call_up  = r_call_up;
  assign call_dn  = r_call_dn;
  assign call_any = r_call_any;
  assign seg3     = r_seg3;
  assign seg2     = r_seg2;
  assign seg1     = r_seg1;
  assign seg0     = r_seg0;

endmodule

// File: tb/tb_floor_call_panel.sv
// Directed bench for floor_call_panel (N_FLOORS=4, DB_COUNT=4, active-high).
module tb_floor_call_panel;

  logic       clk = 1'b0;
  logic       resetb, slowref;
  logic [3:0] pb_up, pb_dn;
  logic [1:0] clr_floor, car_floor;
  logic       clrup, clrdn, moving, upsig, dnsig;
  logic [7:0] pbpulse;
  logic [3:0] call_up, call_dn;
  logic       call_any;
  logic [7:0] seg3, seg2, seg1, seg0;

  int n_tests = 0;
  int n_fail  = 0;
  int tick    = 0;
  int sr_div  = 4;

  floor_call_panel #(.N_FLOORS(4), .DB_COUNT(4), .PB_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .resetb(resetb), .slowref(slowref),
    .pb_up(pb_up), .pb_dn(pb_dn),
    .clr_floor(clr_floor), .clrup(clrup), .clrdn(clrdn),
    .car_floor(car_floor), .moving(moving), .upsig(upsig), .dnsig(dnsig),
    .pbpulse(pbpulse), .call_up(call_up), .call_dn(call_dn), .call_any(call_any),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] car;
    logic       mv, up, dn;
    logic [7:0] s3, s2, s1, s0;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive slowref for the coming edge, then sample 1 unit after it
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      slowref = (sr_div <= 1) ? 1'b1 : ((tick % sr_div) == 0);
      tick++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bit(input int b, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cyc(1);
      if (pbpulse[b]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         ok, seen;
    int         pulses, k;
    logic [7:0] acc;

    tbl[0] = '{2'd2, 1'b1, 1'b1, 1'b0, 8'hC1, 8'h8C, 8'hFF, 8'hA4};
    tbl[1] = '{2'd2, 1'b1, 1'b0, 1'b1, 8'hA1, 8'hAB, 8'hFF, 8'hA4};
    tbl[2] = '{2'd2, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hA4};
    tbl[3] = '{2'd3, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hB0};
    tbl[4] = '{2'd1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hF9};
    tbl[5] = '{2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    tbl[6] = '{2'd1, 1'b1, 1'b1, 1'b0, 8'hC1, 8'h8C, 8'hFF, 8'hF9};
    tbl[7] = '{2'd3, 1'b1, 1'b0, 1'b1, 8'hA1, 8'hAB, 8'hFF, 8'hB0};

    resetb = 1'b0; slowref = 1'b0; pb_up = '0; pb_dn = '0;
    clr_floor = '0; clrup = 1'b0; clrdn = 1'b0;
    car_floor = '0; moving = 1'b0; upsig = 1'b0; dnsig = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_call_up", call_up, 4'h0);
    chk("rst_call_dn", call_dn, 4'h0);
    chk("rst_call_any", call_any, 1'b0);
    chk("rst_pbpulse", pbpulse, 8'h00);
    chk("rst_segs", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);

    // Idle after reset
    resetb = 1'b1;
    acc = '0;
    for (int i = 0; i < 64; i++) begin cyc(1); acc |= pbpulse; end
    chk("idle_pbpulse", acc, 8'h00);
    chk("idle_calls", {call_up, call_dn, 3'b000, call_any}, 12'h000);
    chk("idle_segs", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFC0);

    // Bouncing up[1] then held: one pulse, latched one clock later
    moving = 1'b1;
    sr_div = 1;
    for (int i = 0; i < 8; i++) begin pb_up[1] = ~pb_up[1]; cyc(1); end
    chk("bounce_no_pulse", pbpulse, 8'h00);
    pb_up[1] = 1'b1;
    sr_div = 4;
    pulses = 0; seen = 1'b0; k = 0; acc = '0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      acc |= pbpulse;
      if (pbpulse[1]) begin
        pulses++;
        if (!seen) begin seen = 1'b1; k = i; end
      end
      if (seen && i == k + 1) begin
        chk("press_call_up", call_up, 4'b0010);
        chk("press_call_any_lag", call_any, 1'b0);
      end
      if (seen && i == k + 2) chk("press_call_any", call_any, 1'b1);
    end
    chk("press_seen", seen, 1'b1);
    chk("press_one_pulse", pulses, 1);
    chk("press_other_bits", acc, 8'h02);

    // Release: no pulse
    pb_up[1] = 1'b0;
    acc = '0;
    for (int i = 0; i < 40; i++) begin cyc(1); acc |= pbpulse; end
    chk("release_no_pulse", acc, 8'h00);

    // Ignored buttons: dn[0] and up[3]
    pb_dn[0] = 1'b1; pb_up[3] = 1'b1;
    acc = '0;
    for (int i = 0; i < 64; i++) begin cyc(1); acc |= pbpulse; end
    chk("ignored_pulse", acc, 8'h00);
    chk("ignored_calls", {call_up, call_dn}, 8'b0010_0000);
    pb_dn[0] = 1'b0; pb_up[3] = 1'b0;
    cyc(8);

    // Press at the idle car's floor: pulse but no latch
    car_floor = 2'd2; moving = 1'b0;
    pb_up[2] = 1'b1;
    wait_bit(2, 100, ok);
    chk("here_pulse", ok, 1'b1);
    cyc(1);
    chk("here_no_latch", call_up, 4'b0010);
    pb_up[2] = 1'b0;
    cyc(40);

    // Down call at floor 3, then clears
    car_floor = 2'd0; moving = 1'b1;
    pb_dn[3] = 1'b1;
    wait_bit(7, 100, ok);
    chk("dn3_pulse", ok, 1'b1);
    cyc(1);
    chk("dn3_latch", call_dn, 4'b1000);
    pb_dn[3] = 1'b0;
    cyc(40);
    clr_floor = 2'd3; clrup = 1'b1;
    cyc(1);
    clrup = 1'b0;
    chk("clrup3_dn_kept", call_dn, 4'b1000);
    chk("clrup3_up_kept", call_up, 4'b0010);
    clrdn = 1'b1;
    cyc(1);
    clrdn = 1'b0;
    chk("clrdn3", call_dn, 4'b0000);
    pb_dn[3] = 1'b1;
    wait_bit(7, 100, ok);
    chk("dn3_pulse2", ok, 1'b1);
    clr_floor = 2'd3; clrdn = 1'b1;
    cyc(1);
    clrdn = 1'b0;
    chk("clear_wins", call_dn, 4'b0000);
    chk("clear_wins_up", call_up, 4'b0010);
    pb_dn[3] = 1'b0;
    cyc(40);

    // Display vectors
    for (int i = 0; i < 8; i++) begin
      car_floor = tbl[i].car; moving = tbl[i].mv;
      upsig = tbl[i].up; dnsig = tbl[i].dn;
      cyc(1);
      chk($sformatf("disp%0d", i), {seg3, seg2, seg1, seg0},
          {tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0});
    end

    // Asynchronous reset mid-run
    car_floor = 2'd2; moving = 1'b1; upsig = 1'b1; dnsig = 1'b0;
    cyc(2);
    chk("pre_rst_segs", {seg3, seg2}, 16'hC18C);
    #2;
    resetb = 1'b0;
    #1;
    chk("async_rst_segs", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
    chk("async_rst_calls", {call_up, call_dn, 3'b000, call_any}, 12'h000);
    cyc(2);
    resetb = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
